// File: rtl/button_reader.sv
// button_reader
//
// Samples NUM_BTNS raw pushbutton pins, synchronises and debounces each one,
// and reports clean levels plus one-cycle press / release / hold pulses.
// The pulses are also queued (one pending bit per button and event kind) and
// serialised onto a valid/ready event stream, lowest button index first.
//
// Ports:
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   btn_raw      asynchronous button pins (polarity set by ACTIVE_LOW)
//   btn_level    debounced level, 1 = pressed
//   btn_press    one-cycle pulse on each debounced press
//   btn_release  one-cycle pulse on each debounced release
//   btn_hold     one-cycle pulse once per press after HOLD_CYCLES
//   event_valid  event presented
//   event_ready  consumer accepts the presented event
//   event_btn    button index of the presented event
//   event_type   01 press, 10 release, 11 hold
//   overflow     sticky, set when an event is dropped
module button_reader #(
    parameter int CLK_FREQ        = 25_000_000,
    parameter int NUM_BTNS        = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = CLK_FREQ / 100,
    parameter int HOLD_CYCLES     = CLK_FREQ,
    localparam int BTN_W          = (NUM_BTNS > 1) ? $clog2(NUM_BTNS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_hold,
    output logic                event_valid,
    input  logic                event_ready,
    output logic [BTN_W-1:0]    event_btn,
    output logic [1:0]          event_type,
    output logic                overflow
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES);
    localparam int HCW = $clog2(HOLD_CYCLES);
    localparam int NEV = 3 * NUM_BTNS;

    typedef enum logic [1:0] {
        ST_RELEASED = 2'd0,
        ST_PRESSED  = 2'd1,
        ST_HELD     = 2'd2
    } hold_state_t;

    logic [NUM_BTNS-1:0] sync_p0;
    logic [NUM_BTNS-1:0] sync_p1;
    logic [DCW-1:0]      dcnt [NUM_BTNS];
    logic [NUM_BTNS-1:0] fire;
    logic [NUM_BTNS-1:0] press_now;
    logic [NUM_BTNS-1:0] release_now;
    logic [NUM_BTNS-1:0] hold_now;

    hold_state_t         state      [NUM_BTNS];
    hold_state_t         state_next [NUM_BTNS];
    logic [HCW-1:0]      hcnt       [NUM_BTNS];

    logic [NEV-1:0]      pending;
    logic [NEV-1:0]      pend_set;
    logic [NEV-1:0]      pend_clr;
    logic                load;
    logic                sel_found;
    logic [BTN_W-1:0]    sel_btn;
    logic [1:0]          sel_type;

    logic                vld_p2;
    logic [BTN_W-1:0]    btn_p2;
    logic [1:0]          type_p2;

    // ---- Stage p0/p1: polarity normalisation and 2-FF synchroniser ----
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            sync_p0 <= btn_raw ^ {NUM_BTNS{ACTIVE_LOW}};
            sync_p1 <= sync_p0;
        end
    end

    // ---- Debounce: accept a change after DEBOUNCE_CYCLES differing samples ----
    always_comb begin
        fire = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            fire[i] = (sync_p1[i] != btn_level[i]) &&
                      (dcnt[i] == DCW'(DEBOUNCE_CYCLES - 1));
        end
    end

    assign press_now   = fire & ~btn_level;
    assign release_now = fire &  btn_level;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) dcnt[i] <= '0;
            btn_level   <= '0;
            btn_press   <= '0;
            btn_release <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                // An agreeing sample restarts the count, rejecting short glitches.
                if (sync_p1[i] == btn_level[i] || fire[i])
                    dcnt[i] <= '0;
                else
                    dcnt[i] <= dcnt[i] + 1'b1;
            end
            btn_level   <= btn_level ^ fire;
            btn_press   <= press_now;
            btn_release <= release_now;
        end
    end

    // ---- Hold detection: per-button RELEASED / PRESSED / HELD ----
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                state[i] <= ST_RELEASED;
                hcnt[i]  <= '0;
            end
            btn_hold <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                state[i] <= state_next[i];
                if (press_now[i])
                    hcnt[i] <= '0;
                else if (state[i] == ST_PRESSED && !hold_now[i] && !release_now[i])
                    hcnt[i] <= hcnt[i] + 1'b1;
            end
            btn_hold <= hold_now;
        end
    end

    always_comb begin
        hold_now = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            state_next[i] = state[i];
            case (state[i])
                ST_RELEASED: begin
                    if (press_now[i]) state_next[i] = ST_PRESSED;
                end
                ST_PRESSED: begin
                    // A release on the hold edge wins: no hold for that press.
                    if (release_now[i]) begin
                        state_next[i] = ST_RELEASED;
                    end else if (hcnt[i] == HCW'(HOLD_CYCLES - 1)) begin
                        state_next[i] = ST_HELD;
                        hold_now[i]   = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (release_now[i]) state_next[i] = ST_RELEASED;
                end
                default: state_next[i] = ST_RELEASED;
            endcase
        end
    end

    // ---- Stage p2: pending bits and event output register ----
    assign load = !vld_p2 || event_ready;

    always_comb begin
        pend_set  = '0;
        pend_clr  = '0;
        sel_found = 1'b0;
        sel_btn   = '0;
        sel_type  = 2'b00;
        for (int b = 0; b < NUM_BTNS; b++) begin
            pend_set[3*b]     = press_now[b];
            pend_set[3*b + 1] = release_now[b];
            pend_set[3*b + 2] = hold_now[b];
        end
        // Lowest button first; within a button press, release, hold.
        for (int b = 0; b < NUM_BTNS; b++) begin
            for (int t = 0; t < 3; t++) begin
                if (!sel_found && pending[3*b + t]) begin
                    sel_found         = 1'b1;
                    sel_btn           = BTN_W'(b);
                    sel_type          = 2'(t + 1);
                    pend_clr[3*b + t] = load;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pending  <= '0;
            overflow <= 1'b0;
            vld_p2   <= 1'b0;
            btn_p2   <= '0;
            type_p2  <= 2'b00;
        end else begin
            // A new pulse on a bit being drained this edge re-arms it cleanly.
            pending <= (pending & ~pend_clr) | pend_set;
            if (|(pend_set & pending & ~pend_clr))
                overflow <= 1'b1;
            if (load) begin
                vld_p2  <= sel_found;
                btn_p2  <= sel_btn;
                type_p2 <= sel_type;
            end
        end
    end

    assign event_valid = vld_p2;
    assign event_btn   = btn_p2;
    assign event_type  = type_p2;

endmodule

// File: tb/tb_button_reader.sv
// tb_button_reader
//
// Directed bench for button_reader with NUM_BTNS=4, ACTIVE_LOW=1,
// DEBOUNCE_CYCLES=4, HOLD_CYCLES=20. Edge numbers in comments count from the
// first clock edge that samples a new raw value (edge 0).
module tb_button_reader;

    logic       clk;
    logic       rst;
    logic [3:0] btn_raw;
    logic [3:0] btn_level;
    logic [3:0] btn_press;
    logic [3:0] btn_release;
    logic [3:0] btn_hold;
    logic       event_valid;
    logic       event_ready;
    logic [1:0] event_btn;
    logic [1:0] event_type;
    logic       overflow;

    int tests  = 0;
    int failed = 0;

    int cap_btn  [8];
    int cap_type [8];
    int cap_edge [8];
    int nev;
    int nhold;
    int hold_edge;

    button_reader #(
        .CLK_FREQ        (25_000_000),
        .NUM_BTNS        (4),
        .ACTIVE_LOW      (1'b1),
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_hold    (btn_hold),
        .event_valid (event_valid),
        .event_ready (event_ready),
        .event_btn   (event_btn),
        .event_type  (event_type),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_event(input string tag, input int b, input int t);
        chk({tag, "_valid"}, event_valid, 1);
        chk({tag, "_btn"},   event_btn,   b);
        chk({tag, "_type"},  event_type,  t);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst         = 1'b1;
        btn_raw     = 4'hF;
        event_ready = 1'b1;

        // ---------------- reset state ----------------
        tick();
        tick();
        chk("rst_level",    btn_level,   0);
        chk("rst_press",    btn_press,   0);
        chk("rst_release",  btn_release, 0);
        chk("rst_hold",     btn_hold,    0);
        chk("rst_valid",    event_valid, 0);
        chk("rst_btn",      event_btn,   0);
        chk("rst_type",     event_type,  0);
        chk("rst_overflow", overflow,    0);
        rst = 1'b0;
        repeat (3) tick();
        chk("idle_valid", event_valid, 0);

        // ---------------- clean press / release on btn 0 ----------------
        btn_raw[0] = 1'b0;
        repeat (5) tick();                      // edges 0..4
        chk("p0_early_press", btn_press, 0);
        chk("p0_early_level", btn_level, 0);
        tick();                                 // edge 5
        chk("p0_level", btn_level,   4'b0001);
        chk("p0_press", btn_press,   4'b0001);
        chk("p0_novld", event_valid, 0);
        tick();                                 // edge 6
        chk("p0_press_once", btn_press, 0);
        chk_event("p0_ev", 0, 1);
        tick();                                 // edge 7
        chk("p0_ev_gone", event_valid, 0);
        btn_raw[0] = 1'b1;
        repeat (5) tick();                      // edges 8..12
        chk("r0_early", btn_release, 0);
        tick();                                 // edge 13
        chk("r0_release", btn_release, 4'b0001);
        chk("r0_level",   btn_level,   0);
        tick();                                 // edge 14
        chk_event("r0_ev", 0, 2);
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("quiet0_valid", event_valid, 0);
            chk("quiet0_hold",  btn_hold,    0);
        end

        // ---------------- glitch rejection on btn 1 ----------------
        btn_raw[1] = 1'b0;
        repeat (3) tick();
        btn_raw[1] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("glitch_level", btn_level,   0);
            chk("glitch_press", btn_press,   0);
            chk("glitch_valid", event_valid, 0);
        end

        // 6-cycle pulse is long enough to register
        btn_raw[1] = 1'b0;
        repeat (5) tick();                      // edges 0..4
        tick();                                 // edge 5
        chk("p1_press", btn_press, 4'b0010);
        btn_raw[1] = 1'b1;
        tick();                                 // edge 6
        chk_event("p1_ev", 1, 1);
        tick();                                 // edge 7
        chk("p1_ev_gone", event_valid, 0);
        repeat (3) tick();                      // edges 8..10
        tick();                                 // edge 11
        chk("r1_release", btn_release, 4'b0010);
        tick();                                 // edge 12
        chk_event("r1_ev", 1, 2);
        repeat (30) tick();
        chk("quiet1_valid", event_valid, 0);

        // ---------------- hold on btn 2 ----------------
        nev   = 0;
        nhold = 0;
        hold_edge = -1;
        btn_raw[2] = 1'b0;
        for (int e = 0; e <= 50; e++) begin
            tick();
            if (event_valid) begin
                if (nev < 8) begin
                    cap_btn[nev]  = int'(event_btn);
                    cap_type[nev] = int'(event_type);
                    cap_edge[nev] = e;
                end
                nev++;
            end
            if (btn_hold[2]) begin
                nhold++;
                hold_edge = e;
            end
            if (btn_hold[1:0] != 2'b00 || btn_hold[3])
                chk("hold_other_btn", btn_hold, 4'b0100);
            if (e == 39) btn_raw[2] = 1'b1;
        end
        chk("hold_nev",   nev, 3);
        chk("hold_e0_b",  cap_btn[0], 2);
        chk("hold_e0_t",  cap_type[0], 1);
        chk("hold_e0_at", cap_edge[0], 6);
        chk("hold_e1_b",  cap_btn[1], 2);
        chk("hold_e1_t",  cap_type[1], 3);
        chk("hold_e1_at", cap_edge[1], 26);
        chk("hold_e2_b",  cap_btn[2], 2);
        chk("hold_e2_t",  cap_type[2], 2);
        chk("hold_e2_at", cap_edge[2], 46);
        chk("hold_count", nhold, 1);
        chk("hold_edge",  hold_edge, 25);
        repeat (5) tick();

        // ---------------- simultaneous press with backpressure ----------------
        event_ready = 1'b0;
        btn_raw     = 4'b0110;                  // btn 0 and btn 3 pressed
        for (int e = 0; e <= 14; e++) begin
            tick();
            if (e >= 6) chk_event("bp_stall", 0, 1);
            else        chk("bp_pre_valid", event_valid, 0);
        end
        event_ready = 1'b1;
        tick();                                 // edge 15
        chk_event("bp_second", 3, 1);
        chk("bp_overflow", overflow, 0);
        btn_raw = 4'hF;
        tick();                                 // edge 16
        chk("bp_drained", event_valid, 0);
        repeat (4) tick();                      // edges 17..20
        tick();                                 // edge 21
        chk("bp_release", btn_release, 4'b1001);
        tick();                                 // edge 22
        chk_event("bp_rel0", 0, 2);
        tick();                                 // edge 23
        chk_event("bp_rel3", 3, 2);
        tick();                                 // edge 24
        chk("bp_rel_done", event_valid, 0);
        repeat (10) tick();
        chk("bp_no_hold_valid", event_valid, 0);

        // ---------------- overflow on btn 1 ----------------
        event_ready = 1'b0;
        btn_raw     = 4'b1100;                  // btn 0 and btn 1 pressed
        repeat (5) tick();                      // edges 0..4
        tick();                                 // edge 5
        chk("ov_press", btn_press, 4'b0011);
        btn_raw[1] = 1'b1;
        tick();                                 // edge 6
        chk_event("ov_head", 0, 1);
        repeat (4) tick();                      // edges 7..10
        tick();                                 // edge 11
        chk("ov_release1", btn_release, 4'b0010);
        chk("ov_not_yet",  overflow, 0);
        btn_raw[1] = 1'b0;
        repeat (5) tick();                      // edges 12..16
        chk("ov_still_clear", overflow, 0);
        tick();                                 // edge 17
        chk("ov_repress", btn_press, 4'b0010);
        chk("ov_set",     overflow, 1);
        btn_raw = 4'hF;
        repeat (5) tick();                      // edges 18..22
        tick();                                 // edge 23
        chk("ov_release_both", btn_release, 4'b0011);
        tick();                                 // edge 24
        tick();                                 // edge 25
        chk_event("ov_head_stable", 0, 1);
        chk("ov_sticky", overflow, 1);
        event_ready = 1'b1;
        nev = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (event_valid) begin
                if (nev < 8) begin
                    cap_btn[nev]  = int'(event_btn);
                    cap_type[nev] = int'(event_type);
                end
                nev++;
            end
        end
        chk("ov_drain_n",  nev, 3);
        chk("ov_d0_b",     cap_btn[0], 0);
        chk("ov_d0_t",     cap_type[0], 2);
        chk("ov_d1_b",     cap_btn[1], 1);
        chk("ov_d1_t",     cap_type[1], 1);
        chk("ov_d2_b",     cap_btn[2], 1);
        chk("ov_d2_t",     cap_type[2], 2);
        chk("ov_persists", overflow, 1);

        // ---------------- reset mid-operation ----------------
        event_ready = 1'b0;
        btn_raw     = 4'b1010;                  // btn 0 and btn 2 pressed
        repeat (5) tick();                      // edges 0..4
        tick();                                 // edge 5
        chk("mr_press", btn_press, 4'b0101);
        tick();                                 // edge 6
        chk_event("mr_head", 0, 1);
        tick();                                 // edge 7
        rst        = 1'b1;
        btn_raw[2] = 1'b1;
        tick();                                 // reset edge
        chk("mr_level",    btn_level,   0);
        chk("mr_press0",   btn_press,   0);
        chk("mr_release",  btn_release, 0);
        chk("mr_hold",     btn_hold,    0);
        chk("mr_valid",    event_valid, 0);
        chk("mr_btn",      event_btn,   0);
        chk("mr_type",     event_type,  0);
        chk("mr_overflow", overflow,    0);
        rst = 1'b0;
        for (int e = 0; e < 5; e++) begin       // sampling edges 0..4
            tick();
            chk("mr_wait_press", btn_press,   0);
            chk("mr_wait_valid", event_valid, 0);
        end
        tick();                                 // edge 5
        chk("mr_repress",  btn_press, 4'b0001);
        chk("mr_level1",   btn_level, 4'b0001);
        chk("mr_ov_clear", overflow, 0);
        tick();                                 // edge 6
        chk_event("mr_ev", 0, 1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/button_reader.md
# button_reader

Input-side companion to the board's LED output logic. Samples `NUM_BTNS` raw pushbutton pins, synchronises and debounces each one, and reports clean levels plus one-cycle press, release and hold pulses. It also serialises those pulses into a valid/ready event stream for a downstream controller, such as the logic that steers the LED pattern.

## Interface
- `CLK_FREQ`, 25_000_000: clock frequency in Hz, used only for default derivation.
- `NUM_BTNS`, 4: number of button inputs, range 1..8.
- `ACTIVE_LOW`, 1: 1 means a pin reading 0 is pressed; 0 means a pin reading 1 is pressed.
- `DEBOUNCE_CYCLES`, `CLK_FREQ/100` (10 ms): number of consecutive differing samples required to accept a change; must be ≥ 2.
- `HOLD_CYCLES`, `CLK_FREQ` (1 s): stable-pressed time before the hold event fires; must be ≥ 2.
- `clk`  in  1  system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `btn_raw`  in  `NUM_BTNS`  asynchronous pins from the board.
- `btn_level`  out  `NUM_BTNS`  debounced state, 1 = pressed.
- `btn_press`  out  `NUM_BTNS`  one-cycle pulse on each debounced press.
- `btn_release`  out  `NUM_BTNS`  one-cycle pulse on each debounced release.
- `btn_hold`  out  `NUM_BTNS`  one-cycle pulse once per press, after `HOLD_CYCLES`.
- `event_valid`  out  1  an event is presented.
- `event_ready`  in  1  consumer accepts the event.
- `event_btn`  out  `$clog2(NUM_BTNS)` (min 1)  index of the button that generated the event.
- `event_type`  out  2  event kind: 01 press, 10 release, 11 hold; 00 is never presented while valid.
- `overflow`  out  1  sticky flag; set when an event is lost.

## Operation
- **Polarity and synchronisation**
  - Raw input is XORed with `ACTIVE_LOW` so that internally 1 = pressed.
  - A 2-FF synchroniser follows for each button.
  - Both synchroniser stages reset to 0 (released).
- **Debounce, per button**
  - Counter `dcnt` is cleared whenever the synchronised sample equals `btn_level`.
  - Otherwise `dcnt` increments.
  - When the sample differs and `dcnt == DEBOUNCE_CYCLES-1`:
    - `btn_level` toggles and `dcnt` clears;
    - `btn_press` pulses if the new level is 1, `btn_release` pulses if it is 0.
  - Any agreeing sample restarts the count, so glitches shorter than `DEBOUNCE_CYCLES` samples are ignored.
- **Per-button states**
  - RELEASED → PRESSED on a debounced press; the hold counter clears.
  - PRESSED: the hold counter increments each cycle. When it reaches `HOLD_CYCLES-1`, `btn_hold` pulses and the state moves to HELD, where the counter stops.
  - PRESSED or HELD → RELEASED on a debounced release.
  - No hold pulse is generated if the button is released before the hold time.
- **Event queue**
  - There is one pending bit per (button, type), `3*NUM_BTNS` bits in total.
  - Each pulse sets its pending bit on the same edge the pulse is asserted.
  - If a pulse occurs while its pending bit is already set, `overflow` sets and stays set until `rst`. The event is dropped, since the bit is already set.
- **Output register**
  - Loads when it is empty, or when `event_valid && event_ready` at this edge.
  - Source: the pending bit with the lowest button index; within a button, the order is press, then release, then hold.
  - The loaded pending bit clears on the same edge.
  - A pulse arriving on the same edge that its own bit is loaded leaves that bit set, with no overflow.
- `event_btn` and `event_type` hold stable while `event_valid` is 1 and `event_ready` is 0.
- `event_valid` never drops without a transfer.

## Timing
- **Reset**: on any edge with `rst = 1`, every output is 0 and all counters, states, pending bits and the output register clear. This is the same mid-operation: in-flight debounce and queued events are discarded.
- **Button held through reset**: reported as a press `DEBOUNCE_CYCLES+1` edges after `rst` deasserts, i.e. after sampling restarts.
- **Debounce latency**: let edge 0 be the first edge that samples a new, stable raw value. `btn_level` and the press/release pulse are updated at edge `DEBOUNCE_CYCLES+1`.
- **Hold latency**: the `btn_hold` pulse occurs `HOLD_CYCLES` edges after the `btn_press` edge.
- **Event latency**: `event_valid` rises one edge after the pulse edge if the output register is empty.
- **Throughput**: back-to-back events are presented every cycle while `event_ready = 1`.
- **Concurrency**: simultaneous pulses on different buttons are all captured; they drain in index order.

## Test plan
Parameters: `NUM_BTNS=4`, `ACTIVE_LOW=1`, `DEBOUNCE_CYCLES=4`, `HOLD_CYCLES=20`.

- **Clean press**: `btn_raw[0]` 1→0 and held, `event_ready=1` → `btn_level[0]=1` and `btn_press[0]` pulses exactly 5 edges after the first sampling edge. `event_valid` follows 1 cycle later with btn 0, type 01, for 1 cycle.
- **Glitch**: a 3-cycle low pulse on `btn_raw[1]` → no level change, no pulses, `event_valid` stays 0. A 6-cycle low pulse → press and, later, release events for btn 1.
- **Hold**: hold btn 2 for 40 cycles, then release → events in order: (2,01), (2,11) 20 edges after the press, (2,10). `btn_hold[2]` pulses exactly once.
- **Simultaneous press with backpressure**: press btn 3 and btn 0 on the same cycle with `event_ready=0` for 10 cycles → `event_valid=1` with btn 0 type 01, stable throughout. After ready rises: btn 0 then btn 3 on consecutive cycles; `overflow=0`.
- **Overflow**: `event_ready=0` with btn 1 pressed, released and pressed again (debounced each time) → the second press sets `overflow=1`, which persists. After draining, only one press and one release for btn 1 are delivered.
- **Reset mid-operation**: assert `rst` for 1 cycle with 2 events pending and btn 0 held → all outputs 0 on the next cycle. btn 0 press is re-reported 5 edges after `rst` deasserts, and `overflow` is cleared.
